// File: rtl/pipe_csa_addsub_pkg.sv
// ============================================================================
// Module : csa_pkg
// Brief  : Shared opcodes and per-stage control payload for pipe_csa_addsub.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package csa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Control bits that travel with each beat; data vectors are sized per instance.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_csa_addsub_if.sv
// ============================================================================
// Module : pipe_csa_addsub_if
// Brief  : Operand/result handshake bundle for pipe_csa_addsub.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_csa_addsub_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

`default_nettype wire

// File: rtl/pipe_csa_addsub_segment.sv
// ============================================================================
// Module : csa_segment
// Brief  : Combinational carry-select segment: two ripple sums, carry mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csa_segment #(
  parameter int SEG = 16
) (
  input  wire logic [SEG-1:0] a,
  input  wire logic [SEG-1:0] b,
  input  wire logic           cin,
  output logic [SEG-1:0]      sum,
  output logic                cout,
  output logic                cmsb
);

  logic [SEG:0]   c0;
  logic [SEG:0]   c1;
  logic [SEG-1:0] s0;
  logic [SEG-1:0] s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < SEG; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // cmsb is the carry into the top bit, needed for signed overflow detection
  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1[SEG] : c0[SEG];
  assign cmsb = cin ? c1[SEG-1] : c0[SEG-1];

endmodule

`default_nettype wire

// File: rtl/pipe_csa_addsub.sv
// ============================================================================
// Module : pipe_csa_addsub
// Brief  : Pipelined carry-select add/subtract, one segment resolved per stage.
//          Optional macro CSA_SATURATE_EN clamps overflowed results.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_csa_addsub
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  pipe_csa_addsub_if.slave   bus
);

  localparam int NSEG = WIDTH / SEG;

  logic                         enable;
  stage_ctrl_t [NSEG-1:0]       ctrl_q, ctrl_d, st_ctrl;
  logic [NSEG-1:0][WIDTH-1:0]   a_q, a_d, st_a;
  logic [NSEG-1:0][WIDTH-1:0]   b_q, b_d, st_b;
  logic [NSEG-1:0][WIDTH-1:0]   sum_q, sum_d, st_sum;
  logic [NSEG-1:0][SEG-1:0]     seg_sum;
  logic [NSEG-1:0]              seg_cout;
  logic [NSEG-1:0]              seg_cmsb;
  logic                         msb_cin_q, msb_cin_d;
  logic                         ovf;
  logic [WIDTH-1:0]             result;
  logic                         unused_ok;

  assign enable       = bus.out_ready || !ctrl_q[NSEG-1].valid;
  assign bus.in_ready = enable;

  // Stage k sees the beat registered by stage k-1; stage 0 sees the input port.
  always_comb begin
    st_a[0]          = bus.in_a;
    st_b[0]          = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
    st_sum[0]        = '0;
    st_ctrl[0].valid = bus.in_valid;
    st_ctrl[0].carry = bus.in_op;
    for (int k = 1; k < NSEG; k++) begin
      st_a[k]    = a_q[k-1];
      st_b[k]    = b_q[k-1];
      st_sum[k]  = sum_q[k-1];
      st_ctrl[k] = ctrl_q[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    csa_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (st_a[k][k*SEG +: SEG]),
      .b    (st_b[k][k*SEG +: SEG]),
      .cin  (st_ctrl[k].carry),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k]),
      .cmsb (seg_cmsb[k])
    );
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    msb_cin_d = msb_cin_q;
    if (enable) begin
      for (int k = 0; k < NSEG; k++) begin
        a_d[k]                = st_a[k];
        b_d[k]                = st_b[k];
        sum_d[k]              = st_sum[k];
        sum_d[k][k*SEG +: SEG] = seg_sum[k];
        ctrl_d[k].valid       = st_ctrl[k].valid;
        ctrl_d[k].carry       = seg_cout[k];
      end
      msb_cin_d = seg_cmsb[NSEG-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      msb_cin_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      msb_cin_q <= msb_cin_d;
    end
  end

  assign ovf = ctrl_q[NSEG-1].carry ^ msb_cin_q;

`ifdef CSA_SATURATE_EN
  // A wrapped sum with MSB set means the true result overflowed positive.
  always_comb begin
    result = sum_q[NSEG-1];
    if (ovf) begin
      result = sum_q[NSEG-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                      : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign result = sum_q[NSEG-1];
`endif

  assign bus.out_valid = ctrl_q[NSEG-1].valid;
  assign bus.out_sum   = result;
  assign bus.out_cout  = ctrl_q[NSEG-1].carry;
  assign bus.out_ovf   = ovf;

  // Final-stage operands and intermediate-segment MSB carries have no consumer.
  assign unused_ok = ^{a_q[NSEG-1], b_q[NSEG-1], seg_cmsb};

endmodule

`default_nettype wire

// File: tb/tb_pipe_csa_addsub.sv
// ============================================================================
// Module : tb_pipe_csa_addsub
// Brief  : Directed + randomized bench for pipe_csa_addsub (WIDTH 32, SEG 16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_csa_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  exp_t exp_q[$];

  logic        prev_stall;
  logic [31:0] prev_sum;
  logic        prev_cout;
  logic        prev_ovf;

  pipe_csa_addsub_if #(.WIDTH(32)) bus ();

  pipe_csa_addsub #(
    .WIDTH (32),
    .SEG   (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  // Reference: signed arithmetic on wide integers, unsigned compare for borrow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    logic [32:0] wide;
    sa = $signed(a);
    sb = $signed(b);
    r  = op ? (sa - sb) : (sa + sb);
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.sum = r[31:0];
    if (op) begin
      e.cout = (a >= b);
    end else begin
      wide   = {1'b0, a} + {1'b0, b};
      e.cout = wide[32];
    end
`ifdef CSA_SATURATE_EN
    if (e.ovf) e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, bus.out_ready || !bus.out_valid});
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_sum", bus.out_sum, prev_sum);
        check("stall_flags", {30'd0, bus.out_cout, bus.out_ovf}, {30'd0, prev_cout, prev_ovf});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_sum", bus.out_sum, e.sum);
          check("sb_cout", {31'd0, bus.out_cout}, {31'd0, e.cout});
          check("sb_ovf", {31'd0, bus.out_ovf}, {31'd0, e.ovf});
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.out_sum;
      prev_cout  = bus.out_cout;
      prev_ovf   = bus.out_ovf;
    end
  end

  // One isolated beat: offered, accepted, absent one cycle later, present the next.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] xs, input logic xc, input logic xo);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clock);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_sum"}, bus.out_sum, xs);
    check({tag, "_cout"}, {31'd0, bus.out_cout}, {31'd0, xc});
    check({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, xo});
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;
    corners[4] = 32'h0000_FFFF;
    corners[5] = 32'h0001_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] sat_pos;
    logic [31:0] sat_neg;
    int idx;
    int waited;
    n_assert     = 0;
    n_fail       = 0;
    prev_stall   = 1'b0;
    prev_sum     = '0;
    prev_cout    = 1'b0;
    prev_ovf     = 1'b0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_op    = 1'b0;
    bus.out_ready = 1'b0;

`ifdef CSA_SATURATE_EN
    sat_pos = 32'h7FFF_FFFF;
    sat_neg = 32'h8000_0000;
`else
    sat_pos = 32'h8000_0000;
    sat_neg = 32'h7FFF_FFFF;
`endif

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", bus.out_sum, 32'd0);
    check("rst_flags", {30'd0, bus.out_cout, bus.out_ovf}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1;

    // Directed corner cases
    directed("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, sat_pos, 1'b0, 1'b1);
    directed("add_seg_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    directed("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    directed("sub_neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, sat_neg, 1'b1, 1'b1);
    directed("add_wrap_cout", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Four back-to-back beats with a three-cycle output stall
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = !(c >= 2 && c < 5);
      bus.in_valid  = (idx < 4);
      if (idx < 4 && (c == 0 || bus.in_ready)) begin
        bus.in_a  = $urandom;
        bus.in_b  = $urandom;
        bus.in_op = $urandom_range(0, 1);
      end
      @(negedge clock);
      if (c >= 2 && c < 5) begin
        check("b2b_stall_ready", {31'd0, bus.in_ready}, 32'd0);
        check("b2b_stall_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    check("b2b_drained", exp_q.size(), 32'd0);

    // Reset with two beats in flight
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_op    = $urandom_range(0, 1);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("inflight_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("inflight_rst_sum", bus.out_sum, 32'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("inflight_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("inflight_no_out", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clock);
    #1;

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = pick_operand();
      bus.in_b      = pick_operand();
      bus.in_op     = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clock);
      #1;
      waited++;
    end
    check("random_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
